// File: rtl/traffic_gen.sv
// traffic_gen: multi-channel pseudo-random traffic source.
// Each channel runs a free-running Galois LFSR. While the generator is in RUN,
// a channel offers a payload whenever the low byte of its LFSR is below 'rate'.
// Accepted transfers are counted per channel.
// Optional feature: define TRAFFIC_GEN_SAT_EN to make the per-channel counters
// saturate at all-ones instead of wrapping.
//
// Handshake (per channel c): valid[c]/data[c] form the offer. A transfer
// happens on an edge where valid[c]=1 and ready[c]=1. Once valid[c] is raised,
// valid[c] and data[c] stay frozen until that transfer. ready[c] has no effect
// while valid[c]=0.
module traffic_gen #(
    parameter int               CHANNELS = 4,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
    parameter int               CNT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         send,
    input  logic [7:0]                   rate,
    input  logic [CHANNELS-1:0]          ready,
    output logic [CHANNELS-1:0]          valid,
    output logic [CHANNELS*WIDTH-1:0]    data,
    output logic [CHANNELS*CNT_BITS-1:0] count,
    output logic                         done,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    assign state_dbg = state;

    // Control FSM; done is registered and tracks residency in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (send) state <= RUN;
                end
                RUN: begin
                    if (!send) state <= DRAIN;
                end
                DRAIN: begin
                    // send is ignored here; only outstanding offers matter
                    if (valid == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (send) begin
                        state <= RUN;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]    lf;
        logic [WIDTH-1:0]    dat;
        logic [CNT_BITS-1:0] cnt;
        logic                vld;
        logic                hit;
        logic                gen;

        // A draw hits when the LFSR low byte is strictly below the threshold,
        // so rate=0 never hits.
        assign hit = (lf[7:0] < rate);
        assign gen = (state == RUN) && hit;

        // Per-channel LFSR, offer register and transfer counter.
        always_ff @(posedge clk) begin
            if (!reset) begin
                lf  <= SEED + WIDTH'(c);
                vld <= 1'b0;
                dat <= '0;
                cnt <= '0;
            end else begin
                lf <= (lf >> 1) ^ (lf[0] ? TAPS : '0);
                if (vld && ready[c]) begin
`ifdef TRAFFIC_GEN_SAT_EN
                    if (cnt != '1) cnt <= cnt + 1'b1;
`else
                    cnt <= cnt + 1'b1;
`endif
                    // back-to-back: reload immediately if this cycle hits
                    if (gen) dat <= lf;
                    else     vld <= 1'b0;
                end else if (!vld && gen) begin
                    vld <= 1'b1;
                    dat <= lf;
                end
            end
        end

        assign valid[c]                     = vld;
        assign data[c*WIDTH +: WIDTH]       = dat;
        assign count[c*CNT_BITS +: CNT_BITS] = cnt;
    end

endmodule

// File: doc/traffic_gen.md
TRAFFIC_GEN -- requirements
Module: traffic_gen

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4: number of independent traffic channels, 1..16.
REQ-002 SHALL provide parameter WIDTH, default 32: LFSR and payload width, 8..64.
REQ-003 SHALL provide parameter TAPS, default 32'h80200003: Galois LFSR feedback mask, WIDTH bits.
REQ-004 SHALL provide parameter SEED, default 1: nonzero base seed; channel c seeds with SEED+c.
REQ-005 SHALL provide parameter CNT_BITS, default 8: per-channel accepted-transfer counter width.
REQ-006 SHALL provide port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL provide port reset, input, 1: reset, synchronous, active-low.
REQ-008 SHALL provide port send, input, 1: run request, level-sensitive.
REQ-009 SHALL provide port rate, input, 8: injection threshold, compared per channel each cycle.
REQ-010 SHALL provide port ready, input, CHANNELS: per-channel sink acceptance.
REQ-011 SHALL provide port valid, output, CHANNELS: per-channel payload valid.
REQ-012 SHALL provide port data, output, CHANNELS*WIDTH: payloads, channel c at bits [c*WIDTH +: WIDTH].
REQ-013 SHALL provide port count, output, CHANNELS*CNT_BITS: accepted-transfer counts, channel c at [c*CNT_BITS +: CNT_BITS].
REQ-014 SHALL provide port done, output, 1: drain complete.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 SHALL transition IDLE->RUN when send=1; RUN->DRAIN when send=0; DRAIN->DONE when all valid bits are 0; DONE->RUN when send=1. All transitions SHALL take effect on the next edge.
REQ-017 SHALL advance every channel LFSR by one step each cycle out of reset: shift right, XOR TAPS when LSB=1.
REQ-018 SHALL define hit_c = (lfsr_c[7:0] < rate), unsigned; rate=0 SHALL never hit; rate=255 SHALL hit 255/256 of draws.
REQ-019 SHALL, in RUN with valid_c=0 and hit_c, set valid_c=1 and data_c=current lfsr_c on the next edge (1-cycle latency).
REQ-020 SHALL hold valid_c and data_c stable while valid_c=1 and ready_c=0.
REQ-021 SHALL count a transfer when valid_c=1 and ready_c=1 in the same cycle, incrementing count_c on that edge.
REQ-022 SHALL, on transfer in RUN with hit_c, keep valid_c=1 and load new data_c (back-to-back transfers); SHALL otherwise clear valid_c.
REQ-023 SHALL generate no new requests in IDLE, DRAIN, or DONE; pending valids SHALL complete normally in DRAIN.
REQ-024 SHALL ignore ready_c when valid_c=0.
REQ-025 SHALL assert done only in DONE; it SHALL drop on the edge that leaves DONE.
REQ-026 SHALL keep count values across RUN/DRAIN/DONE cycles; only reset clears them.
REQ-027 SHALL, if send toggles 1->0->1 within DRAIN, take no action until DONE.

Reset
REQ-028 SHALL, while reset=0 at a rising edge, set state=IDLE, valid=0, data=0, count=0, done=0, and lfsr_c=SEED+c.
REQ-029 SHALL let reset override all other inputs, including mid-transfer, discarding pending payloads without counting them.
REQ-030 SHALL never allow an LFSR state of zero; this requires SEED+c≠0 for every channel.

Configuration
REQ-031 SHALL, with macro TRAFFIC_GEN_SAT_EN defined, saturate count_c at all-ones with further transfers still accepted; without it, count_c SHALL wrap to 0 after all-ones.

Verification
REQ-032 SHALL verify: reset=0 for 2 cycles, then release with send=0 -> valid=0, count=0, done=0, state remains IDLE.
REQ-033 SHALL verify: rate=255, ready all 1, send=1 for 100 cycles -> each count_c equals the number of hits predicted by a reference LFSR model with seed 1+c; every data value matches the model.
REQ-034 SHALL verify: rate=255, ready_0=0 for 10 cycles -> valid_0 stays 1, data_0 is unchanged, count_0 stays 0; ready_0=1 -> count_0=1 next edge.
REQ-035 SHALL verify: send 1->0 with channel 2 valid and ready_2=0 -> done stays 0; ready_2=1 -> count_2 increments, then done=1 within 2 cycles.
REQ-036 SHALL verify: CNT_BITS=4, 17 transfers -> count=1 without TRAFFIC_GEN_SAT_EN, count=15 with it.
REQ-037 SHALL verify: rate=0, send=1 for 50 cycles -> valid never asserts; send=0 -> done=1 on the second following edge.
